// File: rtl/acumulador_mac_pkg.sv
// Shared fixed-point definitions for the MAC stage and the downstream truncation stage.
// Holds operand geometry, 2N-bit saturation limits and the MAC state encoding.
package acumulador_mac_pkg;

    localparam int N        = 25;
    localparam int FRAC     = 14;
    localparam int MAX_TAPS = 16;
    localparam int W        = 2 * N;
    localparam int CNT_W    = $clog2(MAX_TAPS);

    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACUM  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // A beat closes its frame on in_last or when it is the MAX_TAPS-th beat.
    function automatic logic is_closing(input logic last, input logic [CNT_W-1:0] cnt);
        return last || (cnt == CNT_W'(MAX_TAPS - 1));
    endfunction

endpackage

// File: rtl/acumulador_mac_if.sv
// Sample/coefficient input stream plus the registered result bus of the MAC stage.
// Handshake: a beat transfers on a rising edge where in_valid and in_ready are both high;
// the source holds in_valid/in_last/Dato/Coef stable while in_ready is low.
interface acumulador_mac_if;
    import acumulador_mac_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic signed [N-1:0] Dato;
    logic signed [N-1:0] Coef;
    logic signed [W-1:0] Datos_Sum;
    logic                Ban_List;
    logic                out_valid;
    logic                sat_flag;
    logic                err_len;

    modport master (
        output in_valid, in_last, Dato, Coef,
        input  in_ready, Datos_Sum, Ban_List, out_valid, sat_flag, err_len
    );

    modport slave (
        input  in_valid, in_last, Dato, Coef,
        output in_ready, Datos_Sum, Ban_List, out_valid, sat_flag, err_len
    );

endinterface

// File: rtl/acumulador_mac_sat_add2n.sv
// Combinational 2N-bit signed add, evaluated at 2N+1 bits and clamped to the 2N-bit range.
module sat_add2n
    import acumulador_mac_pkg::*;
(
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y,
    output logic                ovf
);

    logic signed [W:0] sum;

    always_comb begin
        sum = {a[W-1], a} + {b[W-1], b};
        ovf = sum[W] ^ sum[W-1];
        if (!ovf) begin
            y = sum[W-1:0];
        end else if (sum[W]) begin
            y = SAT_MIN;
        end else begin
            y = SAT_MAX;
        end
    end

endmodule

// File: rtl/acumulador_mac.sv
// Two-stage signed multiply-accumulate over framed (Dato, Coef) beats with saturating
// accumulation; publishes each completed frame sum with Ban_List/sat_flag/err_len.
module acumulador_mac
    import acumulador_mac_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    acumulador_mac_if.slave    bus,
    output state_t             state_dbg
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    tap_cnt;
    logic                accept;
    logic                closing;

    logic signed [W-1:0] dato_x, coef_x, prod_d;
    logic signed [W-1:0] prod_q;
    logic                prod_vld, prod_first, prod_close, prod_forced;

    logic signed [W-1:0] acc_q;
    logic                frame_sat_q;
    logic signed [W-1:0] add_y, sum_d;
    logic                add_ovf, sat_d;

    assign bus.in_ready = (state_q != DRAIN);
    assign accept       = bus.in_valid & bus.in_ready;
    assign closing      = is_closing(bus.in_last, tap_cnt);
    assign state_dbg    = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = closing ? DRAIN : ACUM;
            ACUM:    if (accept && closing) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are sign-extended to 2N bits so the low 2N bits of the product are exact.
    assign dato_x = {{N{bus.Dato[N-1]}}, bus.Dato};
    assign coef_x = {{N{bus.Coef[N-1]}}, bus.Coef};
    assign prod_d = dato_x * coef_x;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q      <= '0;
            prod_vld    <= 1'b0;
            prod_first  <= 1'b0;
            prod_close  <= 1'b0;
            prod_forced <= 1'b0;
            tap_cnt     <= '0;
        end else begin
            prod_vld <= accept;
            if (accept) begin
                prod_q      <= prod_d;
                prod_first  <= (state_q == IDLE);
                prod_close  <= closing;
                prod_forced <= closing & ~bus.in_last;
                tap_cnt     <= closing ? '0 : tap_cnt + CNT_W'(1);
            end
        end
    end

    sat_add2n u_sat_add (
        .a   (acc_q),
        .b   (prod_q),
        .y   (add_y),
        .ovf (add_ovf)
    );

    // The first product of a frame replaces the accumulator, so it can never overflow.
    assign sum_d = prod_first ? prod_q : add_y;
    assign sat_d = prod_first ? 1'b0 : (frame_sat_q | add_ovf);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q         <= '0;
            frame_sat_q   <= 1'b0;
            bus.Datos_Sum <= '0;
            bus.Ban_List  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.sat_flag  <= 1'b0;
            bus.err_len   <= 1'b0;
        end else begin
            bus.out_valid <= prod_vld & prod_close;
            if (prod_vld) begin
                acc_q       <= sum_d;
                frame_sat_q <= sat_d;
            end
            if (prod_vld && prod_close) begin
                bus.Datos_Sum <= sum_d;
                bus.sat_flag  <= sat_d;
                bus.err_len   <= prod_forced;
                bus.Ban_List  <= 1'b0;
            end else if (accept && state_q == IDLE) begin
                bus.Ban_List  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_acumulador_mac.sv
// Directed bench for acumulador_mac: hand-computed frame sums, saturation, forced close,
// back-to-back framing and asynchronous reset.
module tb_acumulador_mac;
    import acumulador_mac_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    state_t state_dbg;
    int     n_tests = 0;
    int     n_fail  = 0;

    acumulador_mac_if bus();

    acumulador_mac dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    localparam logic signed [N-1:0] ONE     = 25'sd16384;
    localparam logic signed [N-1:0] TWO     = 25'sd32768;
    localparam logic signed [N-1:0] HALF    = 25'sd8192;
    localparam logic signed [N-1:0] MONE    = -25'sd16384;
    localparam logic signed [N-1:0] THREE   = 25'sd49152;
    localparam logic signed [N-1:0] BIG_NEG = {1'b1, 24'd0};

    localparam logic signed [W-1:0] P28   = 50'sh0_0000_1000_0000;
    localparam logic signed [W-1:0] P29   = 50'sh0_0000_2000_0000;
    localparam logic signed [W-1:0] P30   = 50'sh0_0000_4000_0000;
    localparam logic signed [W-1:0] P32   = 50'sh0_0001_0000_0000;
    localparam logic signed [W-1:0] P48   = 50'sh1_0000_0000_0000;
    localparam logic signed [W-1:0] P49M1 = 50'sh1_FFFF_FFFF_FFFF;

    task automatic beat(input logic signed [N-1:0] d, input logic signed [N-1:0] c,
                        input logic last, output int stalls);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.Dato     = d;
        bus.Coef     = c;
        bus.in_last  = last;
        stalls       = 0;
        while (bus.in_ready !== 1'b1 && stalls < 8) begin
            @(negedge clk);
            stalls++;
        end
        n_tests++; if (stalls >= 8) begin n_fail++; $display("FAIL beat_accept_timeout in_ready=%b stalls=%0d", bus.in_ready, stalls); end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.Dato     = '0;
        bus.Coef     = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.Datos_Sum !== '0) begin n_fail++; $display("FAIL reset_sum got %0d exp 0", bus.Datos_Sum); end
        n_tests++; if (bus.Ban_List !== 1'b1) begin n_fail++; $display("FAIL reset_ban got %b exp 1", bus.Ban_List); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        n_tests++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b exp 0", bus.sat_flag); end
        n_tests++; if (bus.err_len !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.err_len); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.in_ready); end
        n_tests++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp IDLE", state_dbg); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int s;
        beat(ONE, ONE, 1'b0, s);
        beat(TWO, HALF, 1'b0, s);
        idle(); tick(); tick();
        n_tests++; if (state_dbg !== ACUM) begin n_fail++; $display("FAIL basic_gap_state got %0d exp ACUM", state_dbg); end
        n_tests++; if (bus.Ban_List !== 1'b1) begin n_fail++; $display("FAIL basic_gap_ban got %b exp 1", bus.Ban_List); end
        beat(MONE, THREE, 1'b1, s);
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_drain_ready got %b exp 0", bus.in_ready); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b exp 0", bus.out_valid); end
        idle(); tick();
        n_tests++; if (bus.Datos_Sum !== -P28) begin n_fail++; $display("FAIL basic_sum got %0d exp %0d", bus.Datos_Sum, -P28); end
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got %b exp 1", bus.out_valid); end
        n_tests++; if (bus.Ban_List !== 1'b0) begin n_fail++; $display("FAIL basic_ban got %b exp 0", bus.Ban_List); end
        n_tests++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL basic_sat got %b exp 0", bus.sat_flag); end
        n_tests++; if (bus.err_len !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b exp 0", bus.err_len); end
        tick();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width got %b exp 0", bus.out_valid); end
        n_tests++; if (bus.Datos_Sum !== -P28) begin n_fail++; $display("FAIL basic_hold got %0d exp %0d", bus.Datos_Sum, -P28); end
    endtask

    task automatic test_single_tap();
        int s;
        beat(BIG_NEG, BIG_NEG, 1'b1, s);
        n_tests++; if (bus.Ban_List !== 1'b1) begin n_fail++; $display("FAIL single_ban_raise got %b exp 1", bus.Ban_List); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready got %b exp 0", bus.in_ready); end
        n_tests++; if (state_dbg !== DRAIN) begin n_fail++; $display("FAIL single_state got %0d exp DRAIN", state_dbg); end
        idle(); tick();
        n_tests++; if (bus.Datos_Sum !== P48) begin n_fail++; $display("FAIL single_sum got %0d exp %0d", bus.Datos_Sum, P48); end
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got %b exp 1", bus.out_valid); end
        n_tests++; if (bus.Ban_List !== 1'b0) begin n_fail++; $display("FAIL single_ban got %b exp 0", bus.Ban_List); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_back got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_saturation();
        int s;
        beat(BIG_NEG, BIG_NEG, 1'b0, s);
        beat(BIG_NEG, BIG_NEG, 1'b0, s);
        beat(BIG_NEG, BIG_NEG, 1'b1, s);
        idle(); tick();
        n_tests++; if (bus.Datos_Sum !== P49M1) begin n_fail++; $display("FAIL sat_sum got %0d exp %0d", bus.Datos_Sum, P49M1); end
        n_tests++; if (bus.sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_flag got %b exp 1", bus.sat_flag); end
        n_tests++; if (bus.err_len !== 1'b0) begin n_fail++; $display("FAIL sat_err got %b exp 0", bus.err_len); end
        beat(ONE, ONE, 1'b1, s);
        idle(); tick();
        n_tests++; if (bus.Datos_Sum !== P28) begin n_fail++; $display("FAIL sat_clean_sum got %0d exp %0d", bus.Datos_Sum, P28); end
        n_tests++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_clear got %b exp 0", bus.sat_flag); end
    endtask

    task automatic test_max_taps();
        int s;
        for (int i = 0; i < 16; i++) beat(ONE, ONE, 1'b0, s);
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL max_ready got %b exp 0", bus.in_ready); end
        idle(); tick();
        n_tests++; if (bus.Datos_Sum !== P32) begin n_fail++; $display("FAIL max_sum got %0d exp %0d", bus.Datos_Sum, P32); end
        n_tests++; if (bus.err_len !== 1'b1) begin n_fail++; $display("FAIL max_err got %b exp 1", bus.err_len); end
        n_tests++; if (bus.Ban_List !== 1'b0) begin n_fail++; $display("FAIL max_ban got %b exp 0", bus.Ban_List); end
        beat(ONE, ONE, 1'b1, s);
        n_tests++; if (bus.Ban_List !== 1'b1) begin n_fail++; $display("FAIL max_next_ban got %b exp 1", bus.Ban_List); end
        n_tests++; if (bus.Datos_Sum !== P32) begin n_fail++; $display("FAIL max_hold got %0d exp %0d", bus.Datos_Sum, P32); end
        idle(); tick();
        n_tests++; if (bus.Datos_Sum !== P28) begin n_fail++; $display("FAIL max_next_sum got %0d exp %0d", bus.Datos_Sum, P28); end
        n_tests++; if (bus.err_len !== 1'b0) begin n_fail++; $display("FAIL max_next_err got %b exp 0", bus.err_len); end
        for (int i = 0; i < 15; i++) beat(ONE, ONE, 1'b0, s);
        beat(ONE, ONE, 1'b1, s);
        idle(); tick();
        n_tests++; if (bus.Datos_Sum !== P32) begin n_fail++; $display("FAIL max_last_sum got %0d exp %0d", bus.Datos_Sum, P32); end
        n_tests++; if (bus.err_len !== 1'b0) begin n_fail++; $display("FAIL max_last_err got %b exp 0", bus.err_len); end
    endtask

    task automatic test_back_to_back();
        int s;
        logic signed [N-1:0] d_tab [3];
        logic signed [W-1:0] e_tab [3];
        d_tab = '{ONE, TWO, MONE};
        e_tab = '{P29, P30, -P29};
        for (int f = 0; f < 3; f++) begin
            beat(d_tab[f], ONE, 1'b0, s);
            n_tests++; if (s !== ((f == 0) ? 0 : 1)) begin n_fail++; $display("FAIL b2b_stalls frame %0d got %0d exp %0d", f, s, (f == 0) ? 0 : 1); end
            if (f > 0) begin
                n_tests++; if (bus.Datos_Sum !== e_tab[f-1]) begin n_fail++; $display("FAIL b2b_prev_sum frame %0d got %0d exp %0d", f, bus.Datos_Sum, e_tab[f-1]); end
                n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse frame %0d got %b exp 0", f, bus.out_valid); end
            end
            beat(d_tab[f], ONE, 1'b1, s);
            n_tests++; if (s !== 0) begin n_fail++; $display("FAIL b2b_inner_stall frame %0d got %0d exp 0", f, s); end
            if (f > 0) begin
                n_tests++; if (bus.Datos_Sum !== e_tab[f-1]) begin n_fail++; $display("FAIL b2b_hold frame %0d got %0d exp %0d", f, bus.Datos_Sum, e_tab[f-1]); end
            end
        end
        idle(); tick();
        n_tests++; if (bus.Datos_Sum !== e_tab[2]) begin n_fail++; $display("FAIL b2b_last_sum got %0d exp %0d", bus.Datos_Sum, e_tab[2]); end
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_last_valid got %b exp 1", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        int s;
        beat(TWO, TWO, 1'b0, s);
        beat(TWO, TWO, 1'b0, s);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        #1;
        n_tests++; if (bus.Datos_Sum !== '0) begin n_fail++; $display("FAIL rmid_sum got %0d exp 0", bus.Datos_Sum); end
        n_tests++; if (bus.Ban_List !== 1'b1) begin n_fail++; $display("FAIL rmid_ban got %b exp 1", bus.Ban_List); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", bus.out_valid); end
        n_tests++; if (bus.sat_flag !== 1'b0) begin n_fail++; $display("FAIL rmid_sat got %b exp 0", bus.sat_flag); end
        n_tests++; if (bus.err_len !== 1'b0) begin n_fail++; $display("FAIL rmid_err got %b exp 0", bus.err_len); end
        n_tests++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL rmid_state got %0d exp IDLE", state_dbg); end
        @(negedge clk);
        reset = 1'b0;
        beat(ONE, ONE, 1'b1, s);
        idle(); tick();
        n_tests++; if (bus.Datos_Sum !== P28) begin n_fail++; $display("FAIL rmid_after_sum got %0d exp %0d", bus.Datos_Sum, P28); end
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_after_valid got %b exp 1", bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_tap();
        test_saturation();
        test_max_taps();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout after %0d tests", n_tests);
        $fatal(1, "simulation time limit reached");
    end

endmodule
